// File: rtl/psum_acc_drain_if.sv
// Bundles the two streams around the drain block: the output-FIFO pop side and the writer-facing result side.
// The master modport is the drain block; the slave modport is whatever sits on both ends (FIFO and writer).
interface psum_acc_drain_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int acc_bw  = 20,
    parameter int num_out = 16,
    parameter int aw      = (num_out > 1) ? $clog2(num_out) : 1
);
    logic                    i_valid;
    logic [col*psum_bw-1:0]  i_data;
    logic                    o_rd;
    logic [col*acc_bw-1:0]   out_data;
    logic [aw-1:0]           out_addr;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  i_valid, i_data, out_ready,
        output o_rd, out_data, out_addr, out_valid
    );

    modport slave (
        output i_valid, i_data, out_ready,
        input  o_rd, out_data, out_addr, out_valid
    );
endinterface

// File: rtl/psum_acc_drain.sv
// Pops column-parallel psums from the output FIFO, accumulates them per output position over num_pass passes, then streams ReLU(acc).
// Latency: first result word is valid the cycle after the final pop; then one word per cycle while out_ready is high.
// Backpressure: FIFO stalls simply pause accumulation; out_ready low holds the registered word stable until accepted.
module psum_acc_drain #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int acc_bw   = 20,
    parameter int num_pass = 9,
    parameter int num_out  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    psum_acc_drain_if.master       bus,
    output logic                   busy,
    output logic                   done
);
    localparam int aw = (num_out  > 1) ? $clog2(num_out)  : 1;
    localparam int pw = (num_pass > 1) ? $clog2(num_pass) : 1;
    localparam logic [aw-1:0] POS_LAST  = aw'(num_out - 1);
    localparam logic [pw-1:0] PASS_LAST = pw'(num_pass - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [pw-1:0]           pass_cnt_q, pass_cnt_d;
    logic [aw-1:0]           pos_cnt_q, pos_cnt_d;
    logic [col*acc_bw-1:0]   acc_q [num_out];
    logic [col*acc_bw-1:0]   acc_d [num_out];
    logic [col*acc_bw-1:0]   out_data_q, out_data_d;
    logic [aw-1:0]           out_addr_q, out_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd;

    // Negative columns clamp to zero; the sign bit alone decides.
    function automatic logic [col*acc_bw-1:0] relu_row(input logic [col*acc_bw-1:0] r);
        relu_row = r;
        for (int c = 0; c < col; c++) begin
            if (r[c*acc_bw + acc_bw - 1]) relu_row[c*acc_bw +: acc_bw] = '0;
        end
    endfunction

    assign rd            = (state_q == ACCUM) && bus.i_valid;
    assign bus.o_rd      = rd;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_comb begin
        logic [acc_bw-1:0] ps;
        logic [acc_bw-1:0] base;
        state_d    = state_q;
        pass_cnt_d = pass_cnt_q;
        pos_cnt_d  = pos_cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        ps         = '0;
        base       = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    pass_cnt_d = '0;
                    pos_cnt_d  = '0;
                end
            end
            ACCUM: begin
                if (rd) begin
                    // First pass overwrites so nothing from a previous or aborted job survives.
                    for (int c = 0; c < col; c++) begin
                        ps   = {{(acc_bw-psum_bw){bus.i_data[c*psum_bw + psum_bw - 1]}},
                                bus.i_data[c*psum_bw +: psum_bw]};
                        base = (pass_cnt_q == '0) ? '0 : acc_q[pos_cnt_q][c*acc_bw +: acc_bw];
                        acc_d[pos_cnt_q][c*acc_bw +: acc_bw] = base + ps;
                    end
                    if (pos_cnt_q == POS_LAST) begin
                        pos_cnt_d = '0;
                        if (pass_cnt_q == PASS_LAST) state_d = EMIT;
                        else                         pass_cnt_d = pass_cnt_q + 1'b1;
                    end else begin
                        pos_cnt_d = pos_cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (pos_cnt_q == POS_LAST) state_d = DONE;
                    else                       pos_cnt_d = pos_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Load from the next-state view so the word is ready the cycle EMIT is entered.
        if (state_d == EMIT) begin
            out_addr_d = pos_cnt_d;
            out_data_d = relu_row(acc_d[pos_cnt_d]);
        end

        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d == ACCUM) || (state_d == EMIT);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pass_cnt_q  <= '0;
            pos_cnt_q   <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < num_out; i++) acc_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            pos_cnt_q   <= pos_cnt_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_psum_acc_drain.sv
// Directed job sequence with random psums; expected words come from summing each position's psums over all passes, wrapping and clamping.
module tb_psum_acc_drain;
    localparam int COL  = 8;
    localparam int PBW  = 16;
    localparam int ABW  = 20;
    localparam int NP   = 9;
    localparam int NO   = 16;
    localparam int NPOP = NP * NO;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    psum_acc_drain_if #(.col(COL), .psum_bw(PBW), .acc_bw(ABW), .num_out(NO)) bus ();

    psum_acc_drain #(.col(COL), .psum_bw(PBW), .acc_bw(ABW), .num_pass(NP), .num_out(NO)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    int checks = 0;
    int errors = 0;
    int psum [NP][NO][COL];
    logic [COL*ABW-1:0] exp_row [NO];

    task automatic chk(input string tag, input logic [COL*ABW-1:0] obs, input logic [COL*ABW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_const(input int v);
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < NO; o++)
                for (int c = 0; c < COL; c++) psum[p][o][c] = v;
    endtask

    task automatic fill_rand();
        logic signed [PBW-1:0] v;
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < NO; o++)
                for (int c = 0; c < COL; c++) begin
                    v = PBW'($urandom);
                    psum[p][o][c] = v;
                end
    endtask

    task automatic build_expect();
        int s;
        logic signed [ABW-1:0] w;
        for (int o = 0; o < NO; o++)
            for (int c = 0; c < COL; c++) begin
                s = 0;
                for (int p = 0; p < NP; p++) s += psum[p][o][c];
                w = s[ABW-1:0];
                exp_row[o][c*ABW +: ABW] = (w < 0) ? '0 : w;
            end
    endtask

    task automatic run_job(input string name, input int stall_at, input int bp_addr,
                           input int abort_addr, input bit rdy_rand);
        int pop_idx = 0, words = 0, stall_cnt = 0, bp_cnt = 0, cyc = 0, tmp = 0;
        int bad_ord = 0, bad_stable = 0, bad_abort = 0;
        bit stall_done = 0, bp_done = 0, hold = 0, fin = 0, lat_chk = 0, aborted = 0;
        bit popped, hs;
        logic [COL*ABW-1:0] held_dat;
        logic [3:0]         held_addr;
        logic [COL*PBW-1:0] row;
        build_expect();
        @(posedge clk); #1;
        start = 1'b1;
        while (!fin && cyc < 3000) begin
            cyc++;
            if (cyc == 2) start = 1'b0;
            if (abort_addr >= 0 && bus.out_valid && bus.out_addr == 4'(abort_addr)) begin
                aborted = 1;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk({name, " abort_out_valid"}, bus.out_valid, 1'b0);
                chk({name, " abort_busy"}, busy, 1'b0);
                chk({name, " abort_done"}, done, 1'b0);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (done || bus.out_valid || busy) bad_abort++;
                end
                chk({name, " abort_quiet"}, bad_abort, 0);
                break;
            end
            if (stall_at >= 0 && !stall_done && pop_idx == stall_at) begin
                stall_done = 1;
                stall_cnt = 3;
            end
            if (stall_cnt > 0) begin bus.i_valid = 1'b0; stall_cnt--; end
            else bus.i_valid = 1'b1;
            for (int c = 0; c < COL; c++) begin
                if (pop_idx < NPOP) begin
                    tmp = psum[pop_idx / NO][pop_idx % NO][c];
                    row[c*PBW +: PBW] = tmp[PBW-1:0];
                end else begin
                    row[c*PBW +: PBW] = PBW'($urandom);
                end
            end
            bus.i_data = row;
            if (bp_addr >= 0 && !bp_done && bus.out_valid && bus.out_addr == 4'(bp_addr)) begin
                bp_done = 1;
                bp_cnt = 4;
            end
            if (bp_cnt > 0) begin bus.out_ready = 1'b0; bp_cnt--; end
            else bus.out_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;

            @(negedge clk);
            if (bus.o_rd && (!bus.i_valid || pop_idx >= NPOP || !busy)) bad_ord++;
            if (hold && (bus.out_data !== held_dat || bus.out_addr !== held_addr || !bus.out_valid))
                bad_stable++;
            if (pop_idx == NPOP && !lat_chk) begin
                lat_chk = 1;
                chk({name, " first_valid_latency"}, bus.out_valid, 1'b1);
            end
            popped = bus.o_rd;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (words < NO) begin
                    chk({name, " addr"}, bus.out_addr, words);
                    chk({name, " data"}, bus.out_data, exp_row[words]);
                end else begin
                    chk({name, " extra_word"}, words, NO - 1);
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held_dat = bus.out_data;
            held_addr = bus.out_addr;
            if (done) begin
                chk({name, " words_at_done"}, words, NO);
                chk({name, " pops_at_done"}, pop_idx, NPOP);
                chk({name, " busy_at_done"}, busy, 1'b0);
                chk({name, " valid_at_done"}, bus.out_valid, 1'b0);
                fin = 1;
            end
            @(posedge clk); #1;
            if (popped) pop_idx++;
            if (hs) words++;
        end
        if (!aborted) begin
            chk({name, " completed"}, fin, 1'b1);
            @(negedge clk);
            chk({name, " done_one_cycle"}, done, 1'b0);
            chk({name, " idle_not_busy"}, busy, 1'b0);
        end
        chk({name, " o_rd_legal"}, bad_ord, 0);
        chk({name, " hold_stable"}, bad_stable, 0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data = '1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset o_rd", bus.o_rd, 1'b0);
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset out_addr", bus.out_addr, 0);
        chk("reset out_data", bus.out_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle o_rd", bus.o_rd, 1'b0);
        chk("idle busy", busy, 1'b0);

        fill_const(3);
        run_job("acc27", -1, -1, -1, 1'b0);

        fill_rand();
        for (int p = 0; p < NP; p++)
            for (int o = 0; o < NO; o++) begin
                psum[p][o][0] = -5;
                psum[p][o][1] = 5;
            end
        run_job("clamp", -1, -1, -1, 1'b0);

        fill_const(3);
        run_job("stall", 3 * NO + 5, -1, -1, 1'b0);

        fill_rand();
        run_job("backpressure", -1, 7, -1, 1'b0);

        fill_rand();
        run_job("abort", -1, -1, 5, 1'b0);

        fill_const(1);
        run_job("fresh9", -1, -1, -1, 1'b1);

        fill_rand();
        run_job("random_ready", -1, -1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
